// File: rtl/vai_wrr_tx_mux.sv
// vai_wrr_tx_mux
// Merges NUM_PORTS sub-AFU Tx request streams onto one upstream Tx channel.
// Each port has a skid FIFO. A weighted round-robin arbiter picks the port to
// issue, and the issued request is tagged with its source port ID so replies
// can be steered back.
// Optional feature macro: VAI_MUX_STATS_EN. It adds the per-port issue
// counters and the upstream stall counter.
module vai_wrr_tx_mux #(
    parameter int NUM_PORTS     = 8,
    parameter int DATA_W        = 512,
    parameter int FIFO_DEPTH    = 8,
    parameter int ALMFULL_SLACK = 4,
    parameter int WEIGHT_W      = 4
) (
    input  logic                          pClk,
    input  logic                          pck_cp2af_softReset_n,
    input  logic [NUM_PORTS-1:0]          in_valid,
    input  logic [NUM_PORTS*DATA_W-1:0]   in_data,
    output logic [NUM_PORTS-1:0]          in_almFull,
    input  logic [NUM_PORTS*WEIGHT_W-1:0] port_weight,
    input  logic                          up_almFull,
    output logic                          out_valid,
    output logic [DATA_W-1:0]             out_data,
    output logic [$clog2(NUM_PORTS)-1:0]  out_port,
    output logic [NUM_PORTS-1:0]          ovf_err
`ifdef VAI_MUX_STATS_EN
    ,
    output logic [NUM_PORTS*32-1:0]       issue_cnt,
    output logic [31:0]                   stall_cnt
`endif
);

    localparam int PW = $clog2(NUM_PORTS);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] ALM_C   = CW'(FIFO_DEPTH - ALMFULL_SLACK);

    logic [DATA_W-1:0]   fifoMem   [NUM_PORTS][FIFO_DEPTH];
    logic [AW-1:0]       wrPtr     [NUM_PORTS];
    logic [AW-1:0]       rdPtr     [NUM_PORTS];
    logic [CW-1:0]       count     [NUM_PORTS];
    logic [CW-1:0]       countNext [NUM_PORTS];
    logic [NUM_PORTS-1:0] notEmpty;
    logic [NUM_PORTS-1:0] pushAcc;
    logic [NUM_PORTS-1:0] pushDrop;
    logic [NUM_PORTS-1:0] pop;
    logic [PW-1:0]       ptr;
    logic [PW-1:0]       searchPort;
    logic [PW-1:0]       grantPort;
    logic [PW:0]         searchIdx;
    logic [WEIGHT_W-1:0] credit;
    logic [WEIGHT_W-1:0] creditNext;
    logic [WEIGHT_W-1:0] grantWeight;
    logic                searchFound;
    logic                keepCur;
    logic                issue;

    // Occupancy flags used by the arbiter.
    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            notEmpty[i] = (count[i] != '0);
        end
    end

    // Find the first non-empty port after ptr, wrapping so that ptr itself is checked last.
    always_comb begin
        searchPort  = ptr;
        searchFound = 1'b0;
        searchIdx   = '0;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            searchIdx = {1'b0, ptr} + (PW+1)'(k);
            if (searchIdx >= (PW+1)'(NUM_PORTS)) begin
                searchIdx = searchIdx - (PW+1)'(NUM_PORTS);
            end
            if (!searchFound && notEmpty[searchIdx[PW-1:0]]) begin
                searchFound = 1'b1;
                searchPort  = searchIdx[PW-1:0];
            end
        end
    end

    // Grant decision. Stay on ptr while it has credit and data; otherwise move on and reload credit from the new port's weight.
    always_comb begin
        issue       = !up_almFull && (|notEmpty);
        keepCur     = notEmpty[ptr] && (credit != '0);
        grantPort   = keepCur ? ptr : searchPort;
        grantWeight = port_weight[grantPort*WEIGHT_W +: WEIGHT_W];
        if (keepCur) begin
            creditNext = credit - WEIGHT_W'(1);
        end else if (grantWeight == '0) begin
            creditNext = '0;
        end else begin
            creditNext = grantWeight - WEIGHT_W'(1);
        end
        for (int i = 0; i < NUM_PORTS; i++) begin
            pop[i] = issue && (grantPort == PW'(i));
        end
    end

    // Push acceptance. A full FIFO still accepts a write when it is being popped in the same cycle.
    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            pushAcc[i]   = in_valid[i] && ((count[i] != DEPTH_C) || pop[i]);
            pushDrop[i]  = in_valid[i] && (count[i] == DEPTH_C) && !pop[i];
            countNext[i] = count[i] + CW'(pushAcc[i]) - CW'(pop[i]);
        end
    end

    // FIFO bookkeeping, registered almost-full, and sticky overflow flags.
    always_ff @(posedge pClk or negedge pck_cp2af_softReset_n) begin
        if (!pck_cp2af_softReset_n) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                count[i] <= '0;
                wrPtr[i] <= '0;
                rdPtr[i] <= '0;
            end
            in_almFull <= '0;
            ovf_err    <= '0;
        end else begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                count[i] <= countNext[i];
                if (pushAcc[i]) begin
                    wrPtr[i] <= wrPtr[i] + AW'(1);
                end
                if (pop[i]) begin
                    rdPtr[i] <= rdPtr[i] + AW'(1);
                end
                in_almFull[i] <= (countNext[i] >= ALM_C);
                ovf_err[i]    <= ovf_err[i] | pushDrop[i];
            end
        end
    end

    // FIFO storage has no reset; validity is tracked by the counts and pointers alone.
    always_ff @(posedge pClk) begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (pushAcc[i]) begin
                fifoMem[i][wrPtr[i]] <= in_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Arbitration state and the registered output request.
    always_ff @(posedge pClk or negedge pck_cp2af_softReset_n) begin
        if (!pck_cp2af_softReset_n) begin
            ptr       <= '0;
            credit    <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_port  <= '0;
        end else if (issue) begin
            ptr       <= grantPort;
            credit    <= creditNext;
            out_valid <= 1'b1;
            out_data  <= fifoMem[grantPort][rdPtr[grantPort]];
            out_port  <= grantPort;
        end else begin
            out_valid <= 1'b0;
        end
    end

`ifdef VAI_MUX_STATS_EN
    // Per-port grant counters that wrap, and a saturating count of upstream-stalled cycles that had work pending.
    always_ff @(posedge pClk or negedge pck_cp2af_softReset_n) begin
        if (!pck_cp2af_softReset_n) begin
            issue_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (pop[i]) begin
                    issue_cnt[i*32 +: 32] <= issue_cnt[i*32 +: 32] + 32'd1;
                end
            end
            if (up_almFull && (|notEmpty) && (stall_cnt != 32'hFFFF_FFFF)) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_vai_wrr_tx_mux.sv
// tb_vai_wrr_tx_mux
// Self-checking bench for vai_wrr_tx_mux. A queue-based reference model predicts
// the outputs every cycle. Directed scenarios cover single-request latency, the
// WRR share, upstream backpressure, overflow, push/pop on a full FIFO and reset
// mid-stream. A randomized phase follows the directed scenarios.
module tb_vai_wrr_tx_mux;

    localparam int NP    = 8;
    localparam int DW    = 64;
    localparam int DEPTH = 8;
    localparam int SLACK = 4;
    localparam int WW    = 4;
    localparam int PW    = 3;

    logic                pClk = 1'b0;
    logic                rst_n = 1'b1;
    logic [NP-1:0]       in_valid = '0;
    logic [NP*DW-1:0]    in_data = '0;
    logic [NP-1:0]       in_almFull;
    logic [NP*WW-1:0]    port_weight = '0;
    logic                up_almFull = 1'b0;
    logic                out_valid;
    logic [DW-1:0]       out_data;
    logic [PW-1:0]       out_port;
    logic [NP-1:0]       ovf_err;

    int checks   = 0;
    int failures = 0;
    int seqNum   = 0;

    // reference model state
    logic [DW-1:0] mq [NP][$];
    int            mPtr = 0;
    int            mCredit = 0;
    logic          expValid = 1'b0;
    logic [DW-1:0] expData = '0;
    logic [PW-1:0] expPort = '0;
    logic [NP-1:0] expAlm = '0;
    logic [NP-1:0] expOvf = '0;

    // observation bookkeeping
    bit  cmpEn = 1'b0;
    bit  logEn = 1'b0;
    int  grantLog [$];
    int  outTotal = 0;
    int  portOut [NP];

    vai_wrr_tx_mux #(
        .NUM_PORTS(NP), .DATA_W(DW), .FIFO_DEPTH(DEPTH),
        .ALMFULL_SLACK(SLACK), .WEIGHT_W(WW)
    ) dut (
        .pClk(pClk),
        .pck_cp2af_softReset_n(rst_n),
        .in_valid(in_valid),
        .in_data(in_data),
        .in_almFull(in_almFull),
        .port_weight(port_weight),
        .up_almFull(up_almFull),
        .out_valid(out_valid),
        .out_data(out_data),
        .out_port(out_port),
        .ovf_err(ovf_err)
    );

    always #5 pClk = ~pClk;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    function automatic bit modelEmpty();
        for (int i = 0; i < NP; i++) begin
            if (mq[i].size() != 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    // One clock of the reference: arbitrate from the queues, pop, then apply pushes.
    task automatic modelStep();
        int g = -1;
        int w;
        if (!up_almFull && !modelEmpty()) begin
            if (mq[mPtr].size() > 0 && mCredit > 0) begin
                g = mPtr;
                mCredit = mCredit - 1;
            end else begin
                for (int k = 1; k <= NP; k++) begin
                    int p = (mPtr + k) % NP;
                    if (g < 0 && mq[p].size() > 0) g = p;
                end
                mPtr = g;
                w = int'(port_weight[g*WW +: WW]);
                mCredit = (w == 0) ? 0 : w - 1;
            end
        end
        if (g >= 0) begin
            expValid = 1'b1;
            expData  = mq[g].pop_front();
            expPort  = PW'(g);
        end else begin
            expValid = 1'b0;
        end
        for (int i = 0; i < NP; i++) begin
            if (in_valid[i]) begin
                if (mq[i].size() < DEPTH) mq[i].push_back(in_data[i*DW +: DW]);
                else expOvf[i] = 1'b1;
            end
        end
        for (int i = 0; i < NP; i++) begin
            expAlm[i] = (mq[i].size() >= DEPTH - SLACK);
        end
    endtask

    // Reference model process, reset asynchronously like the DUT.
    initial begin
        forever begin
            @(posedge pClk or negedge rst_n);
            if (!rst_n) begin
                for (int i = 0; i < NP; i++) mq[i].delete();
                mPtr = 0; mCredit = 0;
                expValid = 1'b0; expData = '0; expPort = '0;
                expAlm = '0; expOvf = '0;
            end else begin
                modelStep();
            end
        end
    end

    // Compare process: DUT against model every cycle, sampled just after the edge.
    initial begin
        forever begin
            @(posedge pClk);
            #1;
            if (cmpEn) begin
                checkOutput("out_valid", out_valid, expValid);
                if (expValid) begin
                    checkOutput("out_data", out_data, expData);
                    checkOutput("out_port", out_port, expPort);
                end
                checkOutput("in_almFull", in_almFull, expAlm);
                checkOutput("ovf_err", ovf_err, expOvf);
                if (out_valid) begin
                    outTotal++;
                    portOut[out_port]++;
                    if (logEn) grantLog.push_back(int'(out_port));
                end
            end
        end
    end

    // Watchdog so the run always ends with a summary.
    initial begin
        #1000000;
        failures++;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    task automatic applyStimulus(input logic [NP-1:0] valid, input logic up, input bit gate);
        @(negedge pClk);
        in_valid   = gate ? (valid & ~in_almFull) : valid;
        up_almFull = up;
        for (int i = 0; i < NP; i++) begin
            in_data[i*DW +: DW] = {8'(i), 24'(seqNum), 32'($urandom())};
        end
        seqNum++;
    endtask

    task automatic doReset();
        @(negedge pClk);
        rst_n = 1'b0;
        repeat (2) @(negedge pClk);
        rst_n = 1'b1;
    endtask

    task automatic drainWait(input int maxCycles);
        bit done = 1'b0;
        for (int c = 0; c < maxCycles && !done; c++) begin
            @(negedge pClk);
            if (modelEmpty() && !out_valid && !expValid) done = 1'b1;
        end
        checkOutput("drain_done", done, 1);
    endtask

    task automatic clearCounts();
        outTotal = 0;
        for (int i = 0; i < NP; i++) portOut[i] = 0;
    endtask

    initial begin
        int seq7 [7] = '{0, 1, 1, 2, 2, 2, 3};
        int wrrCnt [4];
        int seqErrs;
        int pushed;
        int stallSeen;
        bit sawValid;

        port_weight = {NP{4'h1}};
        #1 rst_n = 1'b0;
        repeat (3) @(posedge pClk);
        #1;
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_out_data", out_data, 0);
        checkOutput("rst_out_port", out_port, 0);
        checkOutput("rst_in_almFull", in_almFull, 0);
        checkOutput("rst_ovf_err", ovf_err, 0);
        @(negedge pClk);
        rst_n = 1'b1;
        cmpEn = 1'b1;

        // single request: push in cycle N, out_valid in cycle N+2 only
        $display("[TB] single request");
        repeat (3) applyStimulus('0, 1'b0, 1'b0);
        applyStimulus(8'b0000_1000, 1'b0, 1'b0);
        in_data[3*DW +: DW] = 64'hA5;
        @(posedge pClk);
        applyStimulus('0, 1'b0, 1'b0);
        @(posedge pClk);
        #1;
        checkOutput("single_valid", out_valid, 1);
        checkOutput("single_data", out_data, 64'hA5);
        checkOutput("single_port", out_port, 3);
        @(posedge pClk);
        #1;
        checkOutput("single_valid_drop", out_valid, 0);

        // WRR share with weights 1,2,3,0 on ports 0..3
        $display("[TB] WRR share");
        doReset();
        port_weight = {16'h1111, 4'h0, 4'h3, 4'h2, 4'h1};
        grantLog.delete();
        logEn = 1'b1;
        repeat (100) applyStimulus(8'b0000_1111, 1'b0, 1'b1);
        applyStimulus('0, 1'b0, 1'b0);
        drainWait(100);
        logEn = 1'b0;
        checkOutput("wrr_enough_grants", grantLog.size() >= 76, 1);
        seqErrs = 0;
        for (int j = 0; j < 4; j++) wrrCnt[j] = 0;
        for (int n = 0; n < 76 && n < grantLog.size(); n++) begin
            if (grantLog[n] != seq7[(n + 1) % 7]) seqErrs++;
            if (n >= 6 && grantLog[n] < 4) wrrCnt[grantLog[n]]++;
        end
        checkOutput("wrr_sequence_errs", seqErrs, 0);
        checkOutput("wrr_port0_share", wrrCnt[0], 10);
        checkOutput("wrr_port1_share", wrrCnt[1], 20);
        checkOutput("wrr_port2_share", wrrCnt[2], 30);
        checkOutput("wrr_port3_share", wrrCnt[3], 10);

        // upstream backpressure for 20 cycles
        $display("[TB] upstream backpressure");
        port_weight = {NP{4'h1}};
        clearCounts();
        pushed = 0;
        stallSeen = 0;
        for (int c = 0; c < 20; c++) begin
            logic [NP-1:0] m;
            m = {6'($urandom()), 2'b00};
            m[0] = (c < 4);
            m[1] = (c < 3);
            applyStimulus(m, 1'b1, 1'b1);
            pushed += $countones(in_valid);
            if (out_valid) stallSeen++;
        end
        applyStimulus('0, 1'b1, 1'b0);
        if (out_valid) stallSeen++;
        checkOutput("stall_out_valid_cnt", stallSeen, 0);
        checkOutput("stall_almFull_p0", in_almFull[0], 1);
        checkOutput("stall_almFull_p1", in_almFull[1], 0);
        applyStimulus('0, 1'b0, 1'b0);
        drainWait(200);
        checkOutput("stall_drain_total", outTotal, pushed);

        // overflow on port 5
        $display("[TB] overflow");
        clearCounts();
        for (int c = 0; c < 9; c++) begin
            applyStimulus(8'b0010_0000, 1'b1, 1'b0);
            if (c == 8) checkOutput("ovf_before_ninth", ovf_err[5], 0);
        end
        applyStimulus('0, 1'b1, 1'b0);
        checkOutput("ovf_set", ovf_err[5], 1);
        applyStimulus('0, 1'b0, 1'b0);
        drainWait(100);
        checkOutput("ovf_drain_cnt", portOut[5], 8);
        checkOutput("ovf_sticky", ovf_err[5], 1);

        // full FIFO pushed in the same cycle it is granted
        $display("[TB] full push/pop");
        repeat (8) applyStimulus(8'b0000_0001, 1'b1, 1'b0);
        clearCounts();
        applyStimulus(8'b0000_0001, 1'b0, 1'b0);
        repeat (3) applyStimulus('0, 1'b1, 1'b0);
        checkOutput("full_pp_no_ovf", ovf_err[0], 0);
        checkOutput("full_pp_almFull", in_almFull[0], 1);
        checkOutput("full_pp_one_issued", portOut[0], 1);
        applyStimulus('0, 1'b0, 1'b0);
        drainWait(100);
        checkOutput("full_pp_total", portOut[0], 9);

        // reset while a request is on the output and three ports hold entries
        $display("[TB] reset mid-stream");
        repeat (5) applyStimulus(8'b0001_0110, 1'b1, 1'b0);
        applyStimulus('0, 1'b0, 1'b0);
        sawValid = 1'b0;
        for (int c = 0; c < 4 && !sawValid; c++) begin
            @(posedge pClk);
            #2;
            sawValid = out_valid;
        end
        checkOutput("rst_mid_pre_valid", sawValid, 1);
        rst_n = 1'b0;
        #1;
        checkOutput("rst_mid_out_valid", out_valid, 0);
        checkOutput("rst_mid_almFull", in_almFull, 0);
        checkOutput("rst_mid_ovf", ovf_err, 0);
        repeat (2) @(negedge pClk);
        rst_n = 1'b1;
        clearCounts();
        repeat (20) applyStimulus('0, 1'b0, 1'b0);
        checkOutput("rst_mid_no_stale", outTotal, 0);

        // randomized traffic, weights, backpressure and occasional overflow
        $display("[TB] random traffic");
        for (int b = 0; b < 5; b++) begin
            for (int i = 0; i < NP; i++) port_weight[i*WW +: WW] = 4'($urandom_range(0, 15));
            for (int c = 0; c < 300; c++) begin
                applyStimulus(NP'($urandom()), ($urandom_range(0, 3) == 0), ($urandom_range(0, 15) != 0));
            end
        end
        applyStimulus('0, 1'b0, 1'b0);
        drainWait(400);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vai_wrr_tx_mux.md
Name: vai_wrr_tx_mux

Overview:
- Parametrised successor to the fixed 4-AFU request mux.
- Merges NUM_PORTS sub-AFU Tx request streams onto one upstream Tx channel, using a per-port skid FIFO and weighted round-robin (WRR) arbitration.
- Tags each issued request with its source port ID so the upstream response router can steer replies back.
- Sits between the sub-AFU array and the upstream CCI-P port, one instance per Tx channel (c0/c1).

Parameters:
- NUM_PORTS, 8: number of sub-AFU request ports (2..16).
- DATA_W, 512: request payload width in bits (header plus data, opaque to this block).
- FIFO_DEPTH, 8: entries per port FIFO; power of 2, at least 4.
- ALMFULL_SLACK, 4: per-port almost-full asserts when occupancy reaches FIFO_DEPTH-ALMFULL_SLACK or more; must be 1..FIFO_DEPTH-1.
- WEIGHT_W, 4: width of each per-port weight.

Ports:
- pClk, in, 1: CCI-P primary clock; every register is on its rising edge.
- pck_cp2af_softReset_n, in, 1: asynchronous active-low reset.
- in_valid, in, NUM_PORTS: per-port request strobe; the request is accepted the same cycle.
- in_data, in, NUM_PORTS*DATA_W: per-port payload; port i occupies bits [i*DATA_W +: DATA_W].
- in_almFull, out, NUM_PORTS: per-port almost-full (backpressure), registered.
- port_weight, in, NUM_PORTS*WEIGHT_W: WRR weights, quasi-static. A weight of 0 is treated as 1.
- up_almFull, in, 1: upstream almost-full; blocks issue.
- out_valid, out, 1: registered request strobe.
- out_data, out, DATA_W: registered payload.
- out_port, out, $clog2(NUM_PORTS): source port ID of out_data.
- ovf_err, out, NUM_PORTS: sticky per-port overflow flag.

Behaviour:
- Reset (async assert, sync deassert assumed by the integrator) sets:
  - all FIFO counts, read pointers and write pointers to 0;
  - arbitration pointer ptr=0 and credit=0;
  - out_valid=0, out_data=0, out_port=0;
  - in_almFull=0 and ovf_err=0.
- Reset mid-operation discards all queued requests; out_valid drops in the same cycle (asynchronously).
- Push:
  - in_valid[i]=1 writes in_data[i] into FIFO i.
  - If FIFO i is full, the write is dropped, ovf_err[i] is set and stays set until reset, and the count is unchanged.
- Simultaneous push and pop on the same FIFO:
  - count is unchanged;
  - a push to a full FIFO during a pop of that FIFO is accepted, with no overflow.
- in_almFull[i] is the registered value of (count_next[i] >= FIFO_DEPTH-ALMFULL_SLACK).
- Issue condition: up_almFull=0 and at least one FIFO is non-empty.
  - up_almFull=1: no pop takes place, out_valid=0 next cycle, and ptr and credit hold.
- Arbitration, evaluated each issue cycle:
  - If FIFO[ptr] is non-empty and credit>0: grant ptr, then credit--.
  - Otherwise: grant the first non-empty port found searching ptr+1, ptr+2, ... with wrap-around modulo NUM_PORTS (ptr itself is checked last). Then set ptr to the granted port and credit = max(weight[granted],1)-1.
  - The weight is sampled only when credit is reloaded.
  - If the current port empties while it still holds credit, the remaining credit is forfeited at the next search.
- On grant:
  - pop the granted FIFO head;
  - next cycle: out_valid=1, out_data=head, out_port=granted port.
  - Otherwise out_valid=0 next cycle; out_data and out_port hold.
- Latency: a push in cycle N gives the earliest out_valid in cycle N+2 (empty FIFO, no contention, up_almFull=0).
- Throughput: one request per cycle.
- Ordering: FIFO order is preserved within each port; there is no ordering guarantee across ports.
- With all ports continuously busy and weights w_i, port i receives w_i grants in every sum(w) consecutive grants.

Optional Feature:
- Macro: VAI_MUX_STATS_EN.
- Defined:
  - adds output issue_cnt, NUM_PORTS*32 bits: one free-running 32-bit counter per port, incremented on each grant to that port, wrapping at 2^32-1 to 0, reset to 0;
  - adds output stall_cnt, 32 bits: incremented each cycle with up_almFull=1 while any FIFO is non-empty; saturates at 2^32-1.
- Undefined: neither port nor its logic exists, and the functional behaviour is otherwise identical.

Test Plan:
- Single request:
  - Stimulus: reset, then NUM_PORTS=8; port 3 pushes one request with data 0xA5 in cycle 10.
  - Required: out_valid=1, out_data=0xA5, out_port=3 in cycle 12; out_valid=0 in cycle 13.
- WRR share:
  - Stimulus: weights {1,2,3,0,...}; ports 0..3 continuously valid, with the FIFOs never allowed to empty.
  - Required: over 70 grants, ports 0/1/2/3 get 10/20/30/10.
  - Required: the grant sequence in each period is 0,1,1,2,2,2,3.
- Upstream backpressure:
  - Stimulus: up_almFull=1 for 20 cycles while ports push.
  - Required: no out_valid during the stall.
  - Required: in_almFull[i] rises when a FIFO reaches 4 entries (DEPTH 8, SLACK 4).
  - Required: after release, all queued requests drain in per-port order with no loss.
- Overflow:
  - Stimulus: up_almFull=1; port 5 pushes 9 requests.
  - Required: the ninth push is dropped and ovf_err[5]=1; drain returns exactly 8 entries.
  - Required: ovf_err[5] is still 1 afterwards.
- Full and simultaneous push/pop:
  - Stimulus: port 0 FIFO full; up_almFull drops; port 0 pushes in the same cycle as it is granted.
  - Required: no overflow and count stays at 8.
- Reset mid-stream:
  - Stimulus: assert pck_cp2af_softReset_n=0 while out_valid=1 with 3 ports holding queued entries.
  - Required: out_valid=0 immediately and all in_almFull=0.
  - Required: after reset, no stale request is ever issued.
  - If VAI_MUX_STATS_EN is defined: counters read 0 after reset.
